// File: rtl/idct_coef_feeder.sv
// idct_coef_feeder: ping-pong 8x8 coefficient buffer feeding the IDCT core.
// The host fills one bank by address and commits it with a mode; the drain
// side replays each committed bank as a 64-cycle burst, back-to-back when the
// other bank is already waiting.
//
// state  | meaning
// IDLE   | nothing issued, waiting for the drain bank to become full
// STREAM | issuing read addresses rd_idx 0..63 from the drain bank
module idct_coef_feeder #(
  parameter int DW = 16,
  parameter int MW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [5:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          blk_commit,
  input  logic [MW-1:0] blk_mode,
  output logic          fill_ready,
  output logic [DW-1:0] x_out,
  output logic [MW-1:0] mode_out,
  output logic          start_out,
  output logic          x_valid,
  output logic          busy
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem [2][64];
  logic [MW-1:0] mode_q [2];
  logic [1:0]    full, full_nxt;
  logic          fill_sel, drain_sel;
  logic [5:0]    rd_idx, rd_idx_nxt;
  logic          issue, drain_done;
  logic          wr_ok, commit_ok;

  assign fill_ready = !full[fill_sel];
  // Writes are also blocked during reset so a reset cycle never disturbs storage.
  assign wr_ok      = wr_en && fill_ready && !rst;
  assign commit_ok  = blk_commit && fill_ready;
  assign busy       = (state == STREAM) || full[0] || full[1] || x_valid;

  // Coefficient storage; contents survive between blocks and across reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[fill_sel][wr_addr] <= wr_data;
  end

  // Drain sequencing and full-flag update; commit and release never hit the
  // same bank because a full fill bank blocks the commit.
  always_comb begin
    state_nxt  = state;
    rd_idx_nxt = rd_idx;
    issue      = 1'b0;
    drain_done = 1'b0;
    full_nxt   = full;
    case (state)
      IDLE: begin
        if (full[drain_sel]) begin
          state_nxt  = STREAM;
          rd_idx_nxt = 6'd0;
        end
      end
      STREAM: begin
        issue      = 1'b1;
        rd_idx_nxt = rd_idx + 6'd1;
        if (rd_idx == 6'd63) begin
          drain_done = 1'b1;
          rd_idx_nxt = 6'd0;
          if (!full[~drain_sel]) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (drain_done) full_nxt[drain_sel] = 1'b0;
    if (commit_ok)  full_nxt[fill_sel]  = 1'b1;
  end

  // Control state: FSM, read counter, bank flags, pointers and latched modes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_idx    <= 6'd0;
      full      <= 2'b00;
      fill_sel  <= 1'b0;
      drain_sel <= 1'b0;
      mode_q[0] <= '0;
      mode_q[1] <= '0;
    end else begin
      state  <= state_nxt;
      rd_idx <= rd_idx_nxt;
      full   <= full_nxt;
      if (commit_ok) begin
        mode_q[fill_sel] <= blk_mode;
        fill_sel         <= ~fill_sel;
      end
      if (drain_done) drain_sel <= ~drain_sel;
    end
  end

  // Output register one cycle behind the read address; zero between bursts.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_out     <= '0;
      mode_out  <= '0;
      start_out <= 1'b0;
      x_valid   <= 1'b0;
    end else begin
      x_valid   <= issue;
      start_out <= issue && (rd_idx == 6'd0);
      x_out     <= issue ? mem[drain_sel][rd_idx] : '0;
      mode_out  <= issue ? mode_q[drain_sel] : '0;
    end
  end

endmodule

// File: tb/tb_idct_coef_feeder.sv
// Bench for idct_coef_feeder: scoreboard of expected beats (value, mode,
// start flag, output cycle) plus a table of isolated blocks and hand-written
// back-to-back, backpressure and mid-burst reset sequences.
module tb_idct_coef_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        blk_commit = 1'b0;
  logic [1:0]  blk_mode = '0;
  logic        fill_ready;
  logic [15:0] x_out;
  logic [1:0]  mode_out;
  logic        start_out, x_valid, busy;

  idct_coef_feeder #(.DW(16), .MW(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .blk_commit(blk_commit), .blk_mode(blk_mode), .fill_ready(fill_ready),
    .x_out(x_out), .mode_out(mode_out), .start_out(start_out),
    .x_valid(x_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] x;
    logic [1:0]  mode;
    logic        start;
    int          at;
  } beat_t;

  typedef struct {
    logic [15:0] base;
    int          pat;
    logic [1:0]  mode;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
  } vec_t;

  beat_t       sbq[$];
  beat_t       e_mon;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] img [2][64];
  logic        tb_fill = 1'b0;
  int          last_exp = 0;
  logic [15:0] first_x = '0;
  logic [15:0] last_x = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] coef(input logic [15:0] base, input int pat, input int k);
    case (pat)
      1:       return (k % 2 == 0) ? 16'h7FFF : 16'h8000;
      2:       return (k == 63) ? 16'h1234 : base + 16'(k);
      default: return base + 16'(k);
    endcase
  endfunction

  // A burst starts two edges after its commit, or right after the previous
  // burst if that is later (back-to-back case).
  task automatic push_block(input logic bank, input logic [1:0] mode, input int cedge);
    int st;
    st = cedge + 2;
    if (last_exp + 1 > st) st = last_exp + 1;
    for (int k = 0; k < 64; k++)
      sbq.push_back('{x: img[bank][k], mode: mode, start: (k == 0), at: st + k});
    last_exp = st + 63;
  endtask

  // 64 writes; the last one (addr 63) carries the commit.
  task automatic write_block(input logic [15:0] base, input int pat, input logic [1:0] mode,
                             output int cedge);
    for (int k = 0; k < 64; k++) begin
      wr_en      = 1'b1;
      wr_addr    = 6'(k);
      wr_data    = coef(base, pat, k);
      blk_commit = (k == 63);
      blk_mode   = mode;
      img[tb_fill][k] = wr_data;
      @(negedge clk);
    end
    wr_en = 1'b0; blk_commit = 1'b0;
    cedge = cyc;
    push_block(tb_fill, mode, cedge);
    tb_fill = ~tb_fill;
  endtask

  task automatic commit_only(input logic [1:0] mode, output int cedge);
    blk_commit = 1'b1;
    blk_mode   = mode;
    @(negedge clk);
    blk_commit = 1'b0;
    cedge = cyc;
    push_block(tb_fill, mode, cedge);
    tb_fill = ~tb_fill;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d beats outstanding required=0", sbq.size());
      sbq.delete();
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (x_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat actual x=%0h start=%0b required no beat (cycle %0d)",
                 x_out, start_out, cyc);
      end else begin
        e_mon = sbq.pop_front();
        check("beat{x,mode,start,cycle}", {x_out, mode_out, start_out, 32'(cyc)},
              {e_mon.x, e_mon.mode, e_mon.start, 32'(e_mon.at)});
        if (start_out) first_x = x_out;
        last_x = x_out;
      end
    end else if (start_out !== 1'b0) begin
      checks++; errors++;
      $display("FAIL start_without_valid actual=%0b required=0 (cycle %0d)", start_out, cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[5];
    int   c1, c2, c3;

    vt[0] = '{base: 16'hFFE0, pat: 0, mode: 2'b01, exp_first: 16'hFFE0, exp_last: 16'h001F};
    vt[1] = '{base: 16'h7FC0, pat: 0, mode: 2'b10, exp_first: 16'h7FC0, exp_last: 16'h7FFF};
    vt[2] = '{base: 16'h8000, pat: 0, mode: 2'b11, exp_first: 16'h8000, exp_last: 16'h803F};
    vt[3] = '{base: 16'h0000, pat: 2, mode: 2'b00, exp_first: 16'h0000, exp_last: 16'h1234};
    vt[4] = '{base: 16'hFFFF, pat: 1, mode: 2'b01, exp_first: 16'h7FFF, exp_last: 16'h8000};

    // reset then idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle{ready,x,mode,start,valid,busy}",
            {fill_ready, x_out, mode_out, start_out, x_valid, busy}, {1'b1, 21'b0});
    end

    // isolated blocks from the table
    for (int i = 0; i < 5; i++) begin
      write_block(vt[i].base, vt[i].pat, vt[i].mode, c1);
      check("after_commit{busy,ready,valid}", {busy, fill_ready, x_valid}, 3'b110);
      wait_drain(100);
      @(negedge clk);
      check("after_burst{valid,busy,ready}", {x_valid, busy, fill_ready}, 3'b001);
      check("first_coef", first_x, vt[i].exp_first);
      check("last_coef", last_x, vt[i].exp_last);
    end

    // back-to-back: B committed during A's burst, no gap, mode switches at B
    write_block(16'h0100, 0, 2'b00, c1);
    write_block(16'h0200, 0, 2'b11, c2);
    wait_drain(200);
    @(negedge clk);
    check("b2b_end_valid", x_valid, 1'b0);

    // backpressure: both banks full, third write+commit dropped
    write_block(16'h0000, 1, 2'b10, c1);
    write_block(16'h0300, 0, 2'b01, c2);
    check("bp_ready_low", fill_ready, 1'b0);
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 16'h5555; blk_commit = 1'b1; blk_mode = 2'b11;
    @(negedge clk);
    wr_en = 1'b0; blk_commit = 1'b0;
    check("bp_ready_freed", fill_ready, 1'b1);
    // Re-commit the freed bank unwritten: it must replay the first block intact.
    commit_only(2'b00, c3);
    wait_drain(300);
    @(negedge clk);
    check("bp_end{valid,busy}", {x_valid, busy}, 2'b00);

    // reset at coefficient 20 with a second block buffered
    write_block(16'h0040, 0, 2'b10, c1);
    commit_only(2'b11, c2);
    while (cyc < c1 + 22) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("trunc_last_coef", last_x, 16'h0054);
    check("reset_mid{ready,x,mode,start,valid,busy}",
          {fill_ready, x_out, mode_out, start_out, x_valid, busy}, {1'b1, 21'b0});
    sbq.delete();
    last_exp = 0;
    tb_fill  = 1'b0;
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("post_reset{ready,valid,busy}", {fill_ready, x_valid, busy}, 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
